// File: rtl/jam_pkg.sv
// Shared constants and types for the jam cost-table arbiter.
// Optional accumulator build macro: JAM_COST_ACC_EN.
package jam_pkg;

    localparam int CW        = 7;
    localparam int W_BITS    = 3;
    localparam int J_BITS    = 3;
    localparam int BURST_LEN = 8;
    localparam int SUM_W     = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } jam_state_t;

endpackage

// File: rtl/jam_rr_pick.sv
// Combinational round-robin picker.
// First set request at or above ptr wins, else the lowest set one.
module jam_rr_pick
    import jam_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          any
);

    // Upper pass from ptr, then wrap-around pass from 0.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                win[i] = 1'b1;
                any    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                win[i] = 1'b1;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Shares one combinational cost table between NUM_REQ search engines.
// Define JAM_COST_ACC_EN to add the per-burst cost sum output rsp_sum.
module jam_cost_arbiter
    import jam_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int BURST_LEN = jam_pkg::BURST_LEN,
    parameter int CW        = jam_pkg::CW
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*3-1:0] req_j,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [W_BITS-1:0]    beat,
    output logic [W_BITS-1:0]    W,
    output logic [J_BITS-1:0]    J,
    input  logic [CW-1:0]        Cost,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [CW-1:0]        rsp_cost,
    output logic                 rsp_last
`ifdef JAM_COST_ACC_EN
    ,
    output logic [SUM_W-1:0]     rsp_sum
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    jam_state_t          state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       own;
    logic [PW-1:0]       own_nxt;
    logic [PW-1:0]       pick_ptr;
    logic [PW-1:0]       win_idx;
    logic [NUM_REQ-1:0]  pick_req;
    logic [NUM_REQ-1:0]  win;
    logic                any;
    logic                in_burst;
    logic                last_beat;
    logic [J_BITS-1:0]   jsel;

    // One picker serves both the idle grant and the end-of-burst handover.
    jam_rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .win (win),
        .any (any)
    );

    // Picker inputs: mid-burst the owner is excluded and search starts past it.
    always_comb begin
        in_burst  = (state == BURST);
        last_beat = in_burst && (beat == W_BITS'(BURST_LEN - 1));
        own_nxt   = (own == PW'(NUM_REQ - 1)) ? '0 : own + 1'b1;
        pick_req  = in_burst ? (req & ~gnt) : req;
        pick_ptr  = in_burst ? own_nxt : ptr;
    end

    // Winner encode and owner job select.
    always_comb begin
        win_idx = '0;
        jsel    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx = PW'(i);
            end
            if (own == PW'(i)) begin
                jsel = req_j[3*i +: 3];
            end
        end
    end

    // Cost-table address: only driven while a burst is running.
    always_comb begin
        W = in_burst ? beat : '0;
        J = in_burst ? jsel : '0;
    end

    // Grant FSM with locked bursts and round-robin pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            gnt   <= '0;
            beat  <= '0;
            ptr   <= '0;
            own   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state <= BURST;
                        gnt   <= win;
                        own   <= win_idx;
                        beat  <= '0;
                    end
                end
                BURST: begin
                    if (last_beat) begin
                        ptr  <= own_nxt;
                        beat <= '0;
                        if (any) begin
                            gnt <= win;
                            own <= win_idx;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // Register each beat's cost back to its owner one cycle later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid <= '0;
            rsp_cost  <= '0;
            rsp_last  <= 1'b0;
        end else begin
            rsp_valid <= in_burst ? gnt : '0;
            rsp_last  <= last_beat;
            if (in_burst) begin
                rsp_cost <= Cost;
            end
        end
    end

`ifdef JAM_COST_ACC_EN
    // Running burst sum, aligned with rsp_cost; restarts after rsp_last.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_sum <= '0;
        end else if (in_burst) begin
            rsp_sum <= (rsp_last ? '0 : rsp_sum)
                     + {{(SUM_W - CW){1'b0}}, Cost};
        end else if (rsp_last) begin
            rsp_sum <= '0;
        end
    end
`endif

endmodule
